// File: rtl/cfg_readback_rx.sv
// Readback receiver: deserializes SEL-framed SDO bits into words.
// Optional CRC-8 residue check enabled by READBACK_CRC_EN.
module cfg_readback_rx #(
    parameter int FRAME_BITS = 104,
    parameter int WORD_W     = 8,
    parameter int MSB_FIRST  = 1,
    localparam int CW        = $clog2(FRAME_BITS + 1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SEL,
    input  logic              SDO,
    input  logic              BIT_STB,
    output logic [WORD_W-1:0] RX_DATA,
    output logic              RX_VALID,
    input  logic              RX_READY,
    output logic [CW-1:0]     BIT_CNT,
    output logic              FRAME_DONE,
    output logic              ERR_LEN,
    output logic              ERR_OVR
`ifdef READBACK_CRC_EN
    ,
    output logic              CRC_OK
`endif
);

    localparam int IW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] FB_C = CW'(FRAME_BITS);
    localparam logic [IW-1:0] WW_C = IW'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sel_d;
    logic [CW-1:0]     r_bit_cnt;
    logic [IW-1:0]     r_idx;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_err_len;
    logic              r_err_ovr;

    logic              w_start;
    logic              w_take;
    logic              w_extra;
    logic              w_flush;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [IW-1:0]     w_idx_inc;
    logic [IW-1:0]     w_pad_amt;
    logic [WORD_W-1:0] w_pad;
    logic              w_word_full;
    logic              w_complete;
    logic [WORD_W-1:0] w_word;
    logic              w_load;

    // Frame sequencing: start on SEL rise, flush on SEL fall, one-cycle done.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_take      = 1'b0;
        w_extra     = 1'b0;
        w_flush     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (SEL && !r_sel_d) begin
                    w_state_nxt = S_SHIFT;
                    w_start     = 1'b1;
                end
            end
            S_SHIFT: begin
                if (!SEL) begin
                    w_state_nxt = S_FLUSH;
                end else if (BIT_STB) begin
                    if (r_bit_cnt < FB_C) w_take = 1'b1;
                    else w_extra = 1'b1;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_DONE;
                w_flush     = 1'b1;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[WORD_W-2:0], SDO}
                                          : {SDO, r_shift[WORD_W-1:1]};
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_pad_amt   = WW_C - r_idx;
    assign w_pad       = (MSB_FIRST != 0) ? (r_shift << w_pad_amt)
                                          : (r_shift >> w_pad_amt);
    assign w_word_full = w_take && (w_idx_inc == WW_C);
    assign w_complete  = w_word_full || (w_flush && (r_idx != '0));
    assign w_word      = w_flush ? w_pad : w_shift_nxt;
    assign w_load      = w_complete && (!r_rx_valid || RX_READY);

    // State register and SEL edge history (sel_d resets high).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_sel_d <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sel_d <= SEL;
        end
    end

    // Bit capture, word index and sticky error flags for the current frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_err_len <= 1'b0;
            r_err_ovr <= 1'b0;
        end else if (w_start) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_err_len <= 1'b0;
            r_err_ovr <= 1'b0;
        end else begin
            if (w_take) begin
                r_shift   <= w_shift_nxt;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_idx     <= w_word_full ? '0 : w_idx_inc;
            end
            if (w_extra || (w_flush && (r_bit_cnt != FB_C))) r_err_len <= 1'b1;
            if (w_complete && !w_load) r_err_ovr <= 1'b1;
        end
    end

    // Holding register: load a finished word if free or draining this cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_load) begin
            r_rx_data  <= w_word;
            r_rx_valid <= 1'b1;
        end else if (r_rx_valid && RX_READY) begin
            r_rx_valid <= 1'b0;
        end
    end

`ifdef READBACK_CRC_EN
    logic [7:0] r_crc;
    logic       r_crc_ok;
    logic       w_fb;

    assign w_fb = r_crc[7] ^ SDO;

    // CRC-8 (poly 0x07) over accepted bits; residue zero means intact frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_crc    <= '0;
            r_crc_ok <= 1'b0;
        end else if (w_start) begin
            r_crc    <= '0;
            r_crc_ok <= 1'b0;
        end else begin
            if (w_take) r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
            if (r_state == S_DONE) r_crc_ok <= (r_crc == 8'h00);
        end
    end

    assign CRC_OK = r_crc_ok;
`endif

    assign RX_DATA    = r_rx_data;
    assign RX_VALID   = r_rx_valid;
    assign BIT_CNT    = r_bit_cnt;
    assign FRAME_DONE = (r_state == S_DONE);
    assign ERR_LEN    = r_err_len;
    assign ERR_OVR    = r_err_ovr;

endmodule

// File: tb/tb_cfg_readback_rx.sv
// Randomized bench for cfg_readback_rx with a frame-level reference model.
// Honours READBACK_CRC_EN when the design is built with it.
module tb_cfg_readback_rx;

    localparam int FB  = 104;
    localparam int W   = 8;
    localparam int MSB = 1;
    localparam int CW  = $clog2(FB + 1);

    logic          CLK = 0;
    logic          RST_N = 0;
    logic          SEL = 0;
    logic          SDO = 0;
    logic          BIT_STB = 0;
    logic          RX_READY = 0;
    logic [W-1:0]  RX_DATA;
    logic          RX_VALID;
    logic [CW-1:0] BIT_CNT;
    logic          FRAME_DONE;
    logic          ERR_LEN;
    logic          ERR_OVR;
`ifdef READBACK_CRC_EN
    logic          CRC_OK;
`endif

    cfg_readback_rx #(.FRAME_BITS(FB), .WORD_W(W), .MSB_FIRST(MSB)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .SEL(SEL),
        .SDO(SDO),
        .BIT_STB(BIT_STB),
        .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_READY(RX_READY),
        .BIT_CNT(BIT_CNT),
        .FRAME_DONE(FRAME_DONE),
        .ERR_LEN(ERR_LEN),
        .ERR_OVR(ERR_OVR)
`ifdef READBACK_CRC_EN
        ,
        .CRC_OK(CRC_OK)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int rmode = 0;
    bit tx[128];

    // Reference model: frame phase, captured bits, holding register.
    int         ph;
    bit         msel_d;
    int         mcnt;
    bit         mbits[128];
    logic [7:0] mdata;
    bit         mval, mlen, movr, mcrc_ok;
    bit         m_comp;
    logic [7:0] m_w;
    logic [7:0] cons[$];

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pack(input int s, input int n);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            if (MSB != 0) w[W-1-i] = mbits[s+i];
            else w[i] = mbits[s+i];
        end
        return w;
    endfunction

    function automatic logic [7:0] crc_of(input bit b[128], input int n);
        logic [7:0] c;
        bit fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = c[7] ^ b[i];
            c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ph = 0; msel_d = 1; mcnt = 0; mval = 0; mdata = 0;
            mlen = 0; movr = 0; mcrc_ok = 0;
        end else begin
            m_comp = 0;
            m_w = 0;
            if (mval && RX_READY) cons.push_back(mdata);
            case (ph)
                0: if (SEL && !msel_d) begin
                    ph = 1; mcnt = 0; mlen = 0; movr = 0; mcrc_ok = 0;
                end
                1: if (!SEL) ph = 2;
                   else if (BIT_STB) begin
                       if (mcnt < FB) begin
                           mbits[mcnt] = SDO;
                           mcnt++;
                           if (mcnt % W == 0) begin
                               m_comp = 1; m_w = pack(mcnt - W, W);
                           end
                       end else mlen = 1;
                   end
                2: begin
                    if (mcnt % W != 0) begin
                        m_comp = 1; m_w = pack(mcnt - mcnt % W, mcnt % W);
                    end
                    if (mcnt != FB) mlen = 1;
                    ph = 3;
                end
                default: begin
                    mcrc_ok = (crc_of(mbits, mcnt) == 8'h00);
                    ph = 0;
                end
            endcase
            if (m_comp) begin
                if (!mval || RX_READY) begin
                    mdata = m_w; mval = 1;
                end else movr = 1;
            end else if (mval && RX_READY) mval = 0;
            msel_d = SEL;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        check("rx_valid", 32'(RX_VALID), 32'(mval));
        check("rx_data", 32'(RX_DATA), 32'(mdata));
        check("bit_cnt", 32'(BIT_CNT), 32'(mcnt));
        check("frame_done", 32'(FRAME_DONE), 32'(ph == 3));
        check("err_len", 32'(ERR_LEN), 32'(mlen));
        check("err_ovr", 32'(ERR_OVR), 32'(movr));
`ifdef READBACK_CRC_EN
        check("crc_ok", 32'(CRC_OK), 32'(mcrc_ok));
`endif
        if (FRAME_DONE === 1'b1) fd_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ready();
        case (rmode)
            0: RX_READY = 1;
            1: RX_READY = 0;
            default: RX_READY = 1'($urandom);
        endcase
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                BIT_STB = 0; SDO = 1'($urandom); set_ready(); tick();
            end
            BIT_STB = 1; SDO = tx[i]; set_ready(); tick();
        end
        BIT_STB = 0;
    endtask

    task automatic run_frame(input int n);
        SEL = 1; set_ready(); tick();
        send_bits(n);
        set_ready(); tick();
        SEL = 0;
        repeat (5) begin set_ready(); tick(); end
    endtask

    task automatic drain();
        RX_READY = 1; tick(); tick();
        cons.delete();
        fd_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] c;
        pat = 8'hA5;
        repeat (3) tick();
        check("rst_valid", 32'(RX_VALID), 0);
        check("rst_bitcnt", 32'(BIT_CNT), 0);
        RST_N = 1;
        tick(); tick();
        drain();

        // 104 bits of 0xA5, always ready
        for (int i = 0; i < FB; i++) tx[i] = pat[7 - i % 8];
        rmode = 0;
        run_frame(FB);
        check("t1_words", cons.size(), 13);
        for (int i = 0; i < cons.size(); i++) check("t1_word", 32'(cons[i]), 32'h a5);
        check("t1_cnt", 32'(BIT_CNT), 104);
        check("t1_len", 32'(ERR_LEN), 0);
        check("t1_ovr", 32'(ERR_OVR), 0);
        check("t1_done", fd_cnt, 1);
        drain();

        // Same frame, consumer stalled
        rmode = 1;
        run_frame(FB);
        check("t2_valid", 32'(RX_VALID), 1);
        check("t2_data", 32'(RX_DATA), 32'h a5);
        check("t2_ovr", 32'(ERR_OVR), 1);
        check("t2_words", cons.size(), 0);
        rmode = 0;
        drain();

        // 100 ones then SEL falls: flush word 0xF0
        for (int i = 0; i < FB; i++) tx[i] = 1;
        run_frame(100);
        check("t3_words", cons.size(), 13);
        if (cons.size() == 13) begin
            check("t3_w11", 32'(cons[11]), 32'h ff);
            check("t3_w12", 32'(cons[12]), 32'h f0);
        end
        check("t3_cnt", 32'(BIT_CNT), 100);
        check("t3_len", 32'(ERR_LEN), 1);
        drain();

        // 106 strobes: extra bits discarded
        for (int i = 0; i < 110; i++) tx[i] = 1'($urandom);
        run_frame(106);
        check("t4_words", cons.size(), 13);
        check("t4_cnt", 32'(BIT_CNT), 104);
        check("t4_len", 32'(ERR_LEN), 1);
        drain();

        // Empty SEL pulse
        run_frame(0);
        check("t5_words", cons.size(), 0);
        check("t5_cnt", 32'(BIT_CNT), 0);
        check("t5_len", 32'(ERR_LEN), 1);
        check("t5_done", fd_cnt, 1);
        drain();

        // Reset mid-frame with SEL held high through release
        SEL = 1; tick();
        send_bits(40);
        RST_N = 0; tick(); tick();
        RST_N = 1;
        cons.delete(); fd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            BIT_STB = 1; SDO = 1'($urandom); tick();
        end
        BIT_STB = 0; tick();
        check("t6_valid", 32'(RX_VALID), 0);
        check("t6_cnt", 32'(BIT_CNT), 0);
        check("t6_done", fd_cnt, 0);
        SEL = 0; tick(); tick();
        for (int i = 0; i < FB; i++) tx[i] = 1'($urandom);
        run_frame(FB);
        check("t6_words", cons.size(), 13);
        check("t6_len", 32'(ERR_LEN), 0);
        drain();

`ifdef READBACK_CRC_EN
        for (int i = 0; i < 96; i++) tx[i] = 1'($urandom);
        c = crc_of(tx, 96);
        for (int i = 0; i < 8; i++) tx[96 + i] = c[7 - i];
        run_frame(FB);
        check("crc_good", 32'(CRC_OK), 1);
        drain();
        tx[17] = ~tx[17];
        run_frame(FB);
        check("crc_bad", 32'(CRC_OK), 0);
        drain();
`else
        c = 8'h00;
`endif

        // Random frames, random consumer
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(0, 110);
            for (int i = 0; i < 128; i++) tx[i] = 1'($urandom);
            rmode = 2;
            run_frame(n);
            rmode = 0;
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfg_readback_rx.md
Name: cfg_readback_rx

Overview:
- Serial readback receiver for the configuration shift chain.
- Captures the SDO bit stream shifted out of the latched config register during a SEL-framed transfer and deserializes it into WORD_W-bit words.
- Delivers words over a valid/ready handshake, reports the frame length, and flags length and overrun errors.
- Sits on the SDO side of the chain. It is the mirror of the FSM that drives SEL/MOSI in, and lets the controller verify a loaded configuration.

Parameters:
- FRAME_BITS, 104, expected bits per frame (88 static + 16 dynamic).
- WORD_W, 8, output word width.
- MSB_FIRST, 1: 1 = first received bit lands in the word MSB; 0 = first bit lands in the LSB.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- SEL  input  1  frame enable, high for the whole transfer.
- SDO  input  1  serial data from the chain.
- BIT_STB  input  1  one-cycle strobe per bit; SDO is valid on this cycle.
- RX_DATA  output  WORD_W  deserialized word.
- RX_VALID  output  1  RX_DATA holds an unconsumed word.
- RX_READY  input  1  consumer accepts the word when RX_VALID&&RX_READY.
- BIT_CNT  output  clog2(FRAME_BITS+1)  bits captured in the current or last frame; saturates at FRAME_BITS.
- FRAME_DONE  output  1  one-cycle pulse at end of frame.
- ERR_LEN  output  1  sticky: frame length differed from FRAME_BITS.
- ERR_OVR  output  1  sticky: a word completed while the holding register was full.
- CRC_OK  output  1  present only with READBACK_CRC_EN.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Internal sel_d = 1, so SEL already high when reset releases is not taken as a frame start.
- States:
  - IDLE -> SHIFT on SEL rising (SEL=1, sel_d=0). On entry: clear BIT_CNT, shift register, ERR_LEN, ERR_OVR. RX_VALID and RX_DATA are untouched.
  - SHIFT:
    - On BIT_STB && SEL with BIT_CNT<FRAME_BITS: shift SDO in per MSB_FIRST and increment BIT_CNT.
    - When the in-word bit index reaches WORD_W: complete the word.
    - A BIT_STB while BIT_CNT==FRAME_BITS sets ERR_LEN; the bit is discarded.
    - SEL falling -> FLUSH.
  - FLUSH (one cycle):
    - If the partial word has n>0 bits, complete it. MSB_FIRST=1: bits left-aligned, zero-padded low. MSB_FIRST=0: bits right-aligned, zero-padded high.
    - If BIT_CNT!=FRAME_BITS, set ERR_LEN.
    - Go to DONE.
  - DONE (one cycle): FRAME_DONE=1 -> IDLE.
- Word completion:
  - If the holding register is empty, or is being consumed this same cycle (RX_VALID&&RX_READY), load RX_DATA and set RX_VALID on the next edge.
  - Latency: RX_VALID rises one cycle after the completing BIT_STB.
  - Otherwise set ERR_OVR; the new word is dropped and RX_DATA is kept.
- RX_VALID clears on handshake unless it is reloaded in the same cycle.
- BIT_STB is ignored when SEL=0 or when the state is not SHIFT.
- A SEL pulse with zero strobes gives FRAME_DONE, BIT_CNT=0, ERR_LEN=1, and no word.
- Reset mid-frame discards the partial word. A new frame needs SEL low, then high.

Optional Feature:
- READBACK_CRC_EN
  - Defined:
    - A CRC-8, poly 0x07, init 0x00, is computed over every accepted bit in arrival order.
    - The register clears on frame start.
    - The last 8 accepted bits of the frame are the transmitted CRC. CRC_OK=1 when the register equals 0 at DONE.
    - CRC_OK is held until the next frame start and is 0 while a frame is in progress.
  - Not defined: the CRC_OK port and CRC logic are absent; all other behaviour is identical.

Test Plan:
- 104 strobes, SDO pattern 0xA5 repeated, MSB_FIRST=1, RX_READY=1 -> 13 words 0xA5, FRAME_DONE once, BIT_CNT=104, ERR_LEN=0, ERR_OVR=0.
- Same frame with RX_READY=0 throughout -> first word 0xA5 held, ERR_OVR=1 after the 2nd word completes, RX_DATA stays 0xA5.
- 100 strobes with bits 1, then SEL falls -> 12 words 0xFF plus flush word 0xF0, BIT_CNT=100, ERR_LEN=1.
- 106 strobes -> 13 words, BIT_CNT=104, ERR_LEN=1; the extra bits produce no word.
- RST_N low after 40 bits, SEL held high through release -> no frame start, no RX_VALID. SEL low then high starts a clean frame; 104 bits -> 13 words.
- READBACK_CRC_EN: 96 data bits + correct CRC-8 -> CRC_OK=1; flip one data bit -> CRC_OK=0.
